hazard_scoreboard: RTL and testbench

//   Parametrised N-lane hazard unit for the superscalar MIPS pipeline.
//   A per-register pending-latency scoreboard replaces pairwise compare logic.
//   It splits intra-bundle RAW/WAW bundles over multiple cycles.
//   It freezes the pipeline on I/D cache miss and kills younger lanes on mispredict.

---
 rtl/hazard_scoreboard_if.sv | 53 +++++
 rtl/hazard_scoreboard.sv | 212 +++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ============================================================================
//  Module      : hazard_scoreboard_if
//  Description : Decode-side bundle, cache status and pipeline control bus
//                connecting the decode stage to the hazard scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_scoreboard_if #(
    parameter int LANES = 2,
    parameter int RW    = 5,
    parameter int LAT_W = 3
);
    // Bundle held in the D stage
    logic [LANES-1:0]       dvalidD;
    logic [LANES*RW-1:0]    rsD;
    logic [LANES*RW-1:0]    rtD;
    logic [LANES-1:0]       usesRsD;
    logic [LANES-1:0]       usesRtD;
    logic [LANES*RW-1:0]    wregD;
    logic [LANES-1:0]       regwriteD;
    logic [LANES*LAT_W-1:0] latD;
    // Branch resolution
    logic                   mispredictD;
    logic [1:0]             brlaneD;
    // Cache status
    logic                   hitF;
    logic                   hitM;
    logic                   memaccM;
    // Pipeline control back to the F/D/E/M/W registers
    logic [LANES-1:0]       issue_mask;
    logic                   stallF;
    logic                   stallD;
    logic                   flushD;
    logic                   flushE;
    logic                   freeze;

    // Decode / pipeline side
    modport master (
        output dvalidD, rsD, rtD, usesRsD, usesRtD, wregD, regwriteD, latD,
        output mispredictD, brlaneD, hitF, hitM, memaccM,
        input  issue_mask, stallF, stallD, flushD, flushE, freeze
    );

    // Scoreboard side
    modport slave (
        input  dvalidD, rsD, rtD, usesRsD, usesRtD, wregD, regwriteD, latD,
        input  mispredictD, brlaneD, hitF, hitM, memaccM,
        output issue_mask, stallF, stallD, flushD, flushE, freeze
    );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : N-lane hazard unit. A per-register pending-latency
//                scoreboard decides which lanes of the D bundle may leave,
//                splits dependent bundles over several cycles, freezes the
//                back end on cache misses and kills younger lanes on a
//                mispredicted branch.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int LANES = 2,
    parameter int NREG  = 32,
    parameter int RW    = 5,
    parameter int LAT_W = 3
) (
    input  wire logic           clk,
    input  wire logic           reset,
    hazard_scoreboard_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [LAT_W-1:0]   r_cnt [NREG];
    logic [LANES-1:0]   r_doneMask;
    logic [LANES-1:0]   w_doneNext;

    // Per-lane unpacked view of the bundle
    logic [RW-1:0]      w_rs    [LANES];
    logic [RW-1:0]      w_rt    [LANES];
    logic [RW-1:0]      w_wr    [LANES];
    logic [LAT_W-1:0]   w_lat   [LANES];
    logic [LAT_W-1:0]   w_cntRs [LANES];
    logic [LAT_W-1:0]   w_cntRt [LANES];
    logic [LAT_W-1:0]   w_cntWr [LANES];

    logic [LANES-1:0]   w_issueRaw;
    logic [LANES-1:0]   w_issue;
    logic               w_elig;
    logic               w_blocked;
    logic               w_missNow;
    logic               w_frozen;
    logic               w_brIssue;
    logic               w_complete;
    logic               w_stallF;
    logic               w_stallD;
    logic               w_flushD;
    logic               w_flushE;

    logic               w_setHit [NREG];
    logic [LAT_W-1:0]   w_setVal [NREG];

    // Slice lane fields and look up the pending latency of each operand
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_rs[i]    = bus.rsD[i*RW +: RW];
        assign w_rt[i]    = bus.rtD[i*RW +: RW];
        assign w_wr[i]    = bus.wregD[i*RW +: RW];
        assign w_lat[i]   = bus.latD[i*LAT_W +: LAT_W];
        assign w_cntRs[i] = (int'(w_rs[i]) < NREG) ? r_cnt[w_rs[i]] : '0;
        assign w_cntRt[i] = (int'(w_rt[i]) < NREG) ? r_cnt[w_rt[i]] : '0;
        assign w_cntWr[i] = (int'(w_wr[i]) < NREG) ? r_cnt[w_wr[i]] : '0;
    end

    // In-order issue: walk remaining lanes, stop at the first one that cannot go
    always_comb begin
        w_issueRaw = '0;
        w_blocked  = 1'b0;
        w_elig     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_elig = 1'b1;
            if (bus.usesRsD[i] && (w_cntRs[i] != '0))
                w_elig = 1'b0;
            if (bus.usesRtD[i] && (w_cntRt[i] != '0))
                w_elig = 1'b0;
            // A younger write must not complete before an older one
            if (bus.regwriteD[i] && (w_cntWr[i] > w_lat[i]))
                w_elig = 1'b0;
            // Intra-bundle RAW/WAW against lower lanes leaving this cycle
            for (int j = 0; j < LANES; j++) begin
                if ((j < i) && w_issueRaw[j] && bus.regwriteD[j] && (w_wr[j] != '0)) begin
                    if ((bus.usesRsD[i]   && (w_rs[i] == w_wr[j])) ||
                        (bus.usesRtD[i]   && (w_rt[i] == w_wr[j])) ||
                        (bus.regwriteD[i] && (w_wr[i] == w_wr[j])))
                        w_elig = 1'b0;
                end
            end
            if (bus.dvalidD[i] && !r_doneMask[i]) begin
                if (!w_blocked && w_elig)
                    w_issueRaw[i] = 1'b1;
                else
                    w_blocked = 1'b1;
            end
        end
    end

    // Does the resolving branch lane leave D this cycle
    always_comb begin
        w_brIssue = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(bus.brlaneD) == i)
                w_brIssue = w_issueRaw[i];
        end
    end

    // Miss FSM next state and pipeline control decisions
    always_comb begin
        w_stateNext = r_state;
        w_missNow   = !bus.hitF || (!bus.hitM && bus.memaccM);
        w_frozen    = 1'b0;
        w_issue     = '0;
        w_complete  = 1'b0;
        w_stallF    = 1'b0;
        w_stallD    = 1'b0;
        w_flushD    = 1'b0;
        w_flushE    = 1'b0;
        w_doneNext  = r_doneMask;

        case (r_state)
            ST_RUN: begin
                if (w_missNow) begin
                    w_frozen    = 1'b1;
                    w_stateNext = ST_MISS;
                end
            end
            ST_MISS: begin
                // Leave the miss in the same cycle the hits come back
                if (w_missNow)
                    w_frozen = 1'b1;
                else
                    w_stateNext = ST_RUN;
            end
            default: w_stateNext = ST_RUN;
        endcase

        if (w_frozen) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
        end else if (bus.mispredictD && w_brIssue) begin
            // Keep the branch and older lanes, drop the wrong path
            for (int i = 0; i < LANES; i++)
                w_issue[i] = w_issueRaw[i] && (i <= int'(bus.brlaneD));
            w_flushD   = 1'b1;
            w_doneNext = '0;
            w_flushE   = (w_issue == '0);
        end else begin
            w_issue    = w_issueRaw;
            w_complete = ((bus.dvalidD & ~(r_doneMask | w_issueRaw)) == '0);
            w_stallF   = !w_complete;
            w_stallD   = !w_complete;
            w_doneNext = w_complete ? '0 : (r_doneMask | w_issueRaw);
            w_flushE   = (w_issueRaw == '0);
        end
    end

    // Destination writes of issuing lanes; the highest lane wins a collision
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_setHit[r] = 1'b0;
            w_setVal[r] = '0;
            for (int i = 0; i < LANES; i++) begin
                if (w_issue[i] && bus.regwriteD[i] && (w_wr[i] == RW'(r))) begin
                    w_setHit[r] = 1'b1;
                    w_setVal[r] = w_lat[i];
                end
            end
        end
    end

    // Pending-latency counters: load on issue, otherwise count down; r0 untracked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                r_cnt[r] <= '0;
        end else if (!w_frozen) begin
            for (int r = 1; r < NREG; r++) begin
                if (w_setHit[r])
                    r_cnt[r] <= w_setVal[r];
                else if (r_cnt[r] != '0)
                    r_cnt[r] <= r_cnt[r] - 1'b1;
            end
        end
    end

    // Miss state and the record of lanes already sent from a split bundle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_doneMask <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_doneMask <= w_doneNext;
        end
    end

    // All control outputs are quiet while reset is held
    assign bus.issue_mask = reset ? '0   : w_issue;
    assign bus.stallF     = reset ? 1'b0 : w_stallF;
    assign bus.stallD     = reset ? 1'b0 : w_stallD;
    assign bus.flushD     = reset ? 1'b0 : w_flushD;
    assign bus.flushE     = reset ? 1'b0 : w_flushE;
    assign bus.freeze     = reset ? 1'b0 : w_frozen;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard (4 lanes) with a
//                behavioural reference model of the scoreboard rules.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam int c_LANES = 4;
    localparam int c_RW    = 5;
    localparam int c_LATW  = 3;

    logic clk;
    logic reset;

    hazard_scoreboard_if #(.LANES(c_LANES), .RW(c_RW), .LAT_W(c_LATW)) bus ();

    hazard_scoreboard #(
        .LANES (c_LANES),
        .NREG  (32),
        .RW    (c_RW),
        .LAT_W (c_LATW)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Stimulus fields for the current cycle
    bit sVld [4], sUrs [4], sUrt [4], sRw [4];
    int sRs [4], sRt [4], sWr [4], sLat [4];
    bit sMisp, sHitF, sHitM, sMem;
    int sBr;

    // Reference model state and the expectations of the last step
    int       mCnt [32];
    bit [3:0] mDone;
    bit [3:0] eMask;
    bit       eStallF, eStallD, eFlushD, eFlushE, eFreeze;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < 32; r++) mCnt[r] = 0;
        mDone = '0;
    endtask

    task automatic clearBundle();
        for (int i = 0; i < 4; i++) begin
            sVld[i] = 0; sUrs[i] = 0; sUrt[i] = 0; sRw[i] = 0;
            sRs[i] = 0;  sRt[i] = 0;  sWr[i] = 0;  sLat[i] = 0;
        end
        sMisp = 0; sBr = 0; sHitF = 1; sHitM = 1; sMem = 0;
    endtask

    task automatic setLane(input int i, input int rs, input bit urs, input int rt, input bit urt,
                           input int wr, input bit rw, input int lat);
        sVld[i] = 1; sRs[i] = rs; sUrs[i] = urs; sRt[i] = rt; sUrt[i] = urt;
        sWr[i] = wr; sRw[i] = rw; sLat[i] = lat;
    endtask

    task automatic randomBundle();
        for (int i = 0; i < 4; i++) begin
            sVld[i] = ($urandom_range(0, 9) < 8);
            sRs[i]  = $urandom_range(0, 7);
            sRt[i]  = $urandom_range(0, 7);
            sWr[i]  = $urandom_range(0, 7);
            sUrs[i] = $urandom_range(0, 1);
            sUrt[i] = $urandom_range(0, 1);
            sRw[i]  = $urandom_range(0, 1);
            sLat[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 1);
        end
    endtask

    task automatic applyInputs();
        for (int i = 0; i < 4; i++) begin
            bus.dvalidD[i]                = sVld[i];
            bus.usesRsD[i]                = sUrs[i];
            bus.usesRtD[i]                = sUrt[i];
            bus.regwriteD[i]              = sRw[i];
            bus.rsD[i*c_RW +: c_RW]       = 5'(sRs[i]);
            bus.rtD[i*c_RW +: c_RW]       = 5'(sRt[i]);
            bus.wregD[i*c_RW +: c_RW]     = 5'(sWr[i]);
            bus.latD[i*c_LATW +: c_LATW]  = 3'(sLat[i]);
        end
        bus.mispredictD = sMisp;
        bus.brlaneD     = 2'(sBr);
        bus.hitF        = sHitF;
        bus.hitM        = sHitM;
        bus.memaccM     = sMem;
    endtask

    // True when every lane in the first k remaining lanes may go together
    function automatic bit prefixOk(input int remL [4], input int k);
        int j, l;
        for (int a = 0; a < k; a++) begin
            j = remL[a];
            if (sUrs[j] && mCnt[sRs[j]] != 0) return 0;
            if (sUrt[j] && mCnt[sRt[j]] != 0) return 0;
            if (sRw[j] && mCnt[sWr[j]] > sLat[j]) return 0;
            for (int b = 0; b < a; b++) begin
                l = remL[b];
                if (sRw[l] && sWr[l] != 0 &&
                    ((sUrs[j] && sRs[j] == sWr[l]) || (sUrt[j] && sRt[j] == sWr[l]) ||
                     (sRw[j] && sWr[j] == sWr[l])))
                    return 0;
            end
        end
        return 1;
    endfunction

    // One clock: drive, predict, compare, then advance the model
    task automatic step();
        int  remL [4];
        int  nRem, k, found;
        bit  miss;
        bit [3:0] mask, vmask;
        @(negedge clk);
        applyInputs();
        #1;
        nRem = 0;
        for (int i = 0; i < 4; i++) remL[i] = 0;
        for (int i = 0; i < 4; i++)
            if (sVld[i] && !mDone[i]) begin remL[nRem] = i; nRem++; end
        k = nRem;
        while (k > 0 && !prefixOk(remL, k)) k--;
        mask = '0;
        for (int a = 0; a < k; a++) mask[remL[a]] = 1'b1;
        for (int i = 0; i < 4; i++) vmask[i] = sVld[i];

        miss = !sHitF || (!sHitM && sMem);
        eFreeze = 0; eStallF = 0; eStallD = 0; eFlushD = 0; eFlushE = 0; eMask = '0;
        if (miss) begin
            eFreeze = 1; eStallF = 1; eStallD = 1;
        end else if (sMisp && mask[sBr]) begin
            for (int i = 0; i < 4; i++) if (i > sBr) mask[i] = 1'b0;
            eMask = mask; eFlushD = 1; eFlushE = (mask == 0);
        end else begin
            eMask = mask; eFlushE = (mask == 0);
            eStallD = ((vmask & ~(mDone | mask)) != 0);
            eStallF = eStallD;
        end

        checkValue("issue_mask", 32'(bus.issue_mask), 32'(eMask));
        checkValue("stallF",     32'(bus.stallF),     32'(eStallF));
        checkValue("stallD",     32'(bus.stallD),     32'(eStallD));
        checkValue("flushD",     32'(bus.flushD),     32'(eFlushD));
        checkValue("flushE",     32'(bus.flushE),     32'(eFlushE));
        checkValue("freeze",     32'(bus.freeze),     32'(eFreeze));

        if (!miss) begin
            for (int r = 1; r < 32; r++) begin
                found = -1;
                for (int i = 0; i < 4; i++)
                    if (eMask[i] && sRw[i] && sWr[i] == r) found = i;
                if (found >= 0)       mCnt[r] = sLat[found];
                else if (mCnt[r] > 0) mCnt[r] = mCnt[r] - 1;
            end
            if (eFlushD || !eStallD) mDone = '0;
            else                     mDone = mDone | eMask;
        end
    endtask

    task automatic idle(input int n);
        clearBundle();
        repeat (n) step();
    endtask

    task automatic checkQuiet(input string tag);
        checkValue({tag, "_mask"},   32'(bus.issue_mask), 32'd0);
        checkValue({tag, "_stallF"}, 32'(bus.stallF),     32'd0);
        checkValue({tag, "_stallD"}, 32'(bus.stallD),     32'd0);
        checkValue({tag, "_flushD"}, 32'(bus.flushD),     32'd0);
        checkValue({tag, "_flushE"}, 32'(bus.flushE),     32'd0);
        checkValue({tag, "_freeze"}, 32'(bus.freeze),     32'd0);
    endtask

    initial begin
        reset = 1'b1;
        clearBundle();
        for (int i = 0; i < 4; i++) setLane(i, 1, 1, 2, 1, 3, 1, 0);
        applyInputs();
        modelReset();
        #12;
        checkQuiet("reset");
        reset = 1'b0;
        idle(2);

        // Load-use: latency 2 producer then dependent reader
        clearBundle(); setLane(0, 0, 0, 0, 0, 8, 1, 2); step();
        checkValue("r8_load", 32'(bus.issue_mask), 32'h1);
        clearBundle(); setLane(0, 8, 1, 0, 0, 9, 1, 0);
        for (int c = 0; c < 2; c++) begin
            step();
            checkValue("r8_wait_mask", 32'(bus.issue_mask), 32'h0);
            checkValue("r8_wait_flushE", 32'(bus.flushE), 32'h1);
            checkValue("r8_wait_stallD", 32'(bus.stallD), 32'h1);
        end
        step();
        checkValue("r8_issue", 32'(bus.issue_mask), 32'h1);
        idle(8);

        // Intra-bundle RAW split over two cycles
        clearBundle(); setLane(0, 0, 0, 0, 0, 3, 1, 0); setLane(1, 3, 1, 0, 0, 0, 0, 0);
        step();
        checkValue("split1_mask", 32'(bus.issue_mask), 32'h1);
        checkValue("split1_stallD", 32'(bus.stallD), 32'h1);
        step();
        checkValue("split2_mask", 32'(bus.issue_mask), 32'h2);
        checkValue("split2_stallD", 32'(bus.stallD), 32'h0);
        idle(8);

        // Writes to r0 never create a dependency
        clearBundle(); setLane(0, 0, 0, 0, 0, 0, 1, 3); setLane(1, 0, 1, 0, 1, 0, 0, 0);
        step();
        checkValue("r0_mask", 32'(bus.issue_mask), 32'h3);
        checkValue("r0_stallD", 32'(bus.stallD), 32'h0);
        idle(8);

        // D-cache miss freezes the scoreboard
        clearBundle(); setLane(0, 0, 0, 0, 0, 4, 1, 2); step();
        clearBundle(); setLane(0, 4, 1, 0, 0, 0, 0, 0); sMem = 1; sHitM = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            checkValue("miss_freeze", 32'(bus.freeze), 32'h1);
            checkValue("miss_flushE", 32'(bus.flushE), 32'h0);
        end
        sHitM = 1;
        step(); checkValue("r4_after_miss_a", 32'(bus.issue_mask), 32'h0);
        step(); checkValue("r4_after_miss_b", 32'(bus.issue_mask), 32'h0);
        step(); checkValue("r4_after_miss_c", 32'(bus.issue_mask), 32'h1);
        idle(8);

        // Mispredict in lane 1 kills lanes 2 and 3
        clearBundle();
        for (int i = 0; i < 4; i++) setLane(i, 20 + i, 1, 24 + i, 1, 10 + i, 1, 0);
        sMisp = 1; sBr = 1;
        step();
        checkValue("misp_mask", 32'(bus.issue_mask), 32'h3);
        checkValue("misp_flushD", 32'(bus.flushD), 32'h1);
        checkValue("misp_stallD", 32'(bus.stallD), 32'h0);
        clearBundle();
        for (int i = 0; i < 4; i++) setLane(i, 10 + i, 1, 0, 0, 14 + i, 1, 0);
        step();
        checkValue("after_misp_mask", 32'(bus.issue_mask), 32'hF);
        idle(8);

        // Reset in the middle of a split bundle with a long pending write
        clearBundle(); setLane(0, 0, 0, 0, 0, 5, 1, 7); step();
        clearBundle(); setLane(0, 0, 0, 0, 0, 3, 1, 0); setLane(1, 3, 1, 0, 0, 0, 0, 0);
        step();
        checkValue("pre_reset_mask", 32'(bus.issue_mask), 32'h1);
        #2 reset = 1'b1;
        #1 checkQuiet("mid_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        modelReset();
        clearBundle();
        setLane(0, 5, 1, 0, 0, 6, 1, 1); setLane(1, 3, 1, 0, 0, 0, 0, 0);
        setLane(2, 7, 1, 0, 0, 0, 0, 0); setLane(3, 0, 0, 3, 1, 2, 1, 0);
        step();
        checkValue("post_reset_mask", 32'(bus.issue_mask), 32'hF);
        idle(4);

        // Randomized traffic; a stalled bundle stays in D until it finishes
        for (int c = 0; c < 3000; c++) begin
            if (!eStallD || eFlushD) randomBundle();
            sHitF = ($urandom_range(0, 9) != 0);
            sHitM = ($urandom_range(0, 3) != 0);
            sMem  = $urandom_range(0, 1);
            sMisp = ($urandom_range(0, 9) == 0);
            sBr   = $urandom_range(0, 3);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
